timing_gen: RTL and testbench

TIMING_GEN -- requirements
Module: timing_gen

---
 rtl/timing_gen_pkg.sv | 14 +
 rtl/timing_gen_if.sv | 20 ++
 rtl/timing_gen.sv | 78 +++++++
 tb/tb_timing_gen.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/timing_gen_pkg.sv
// timing_gen_pkg: shared states, blanking defaults and helpers for timing_gen
package timing_gen_pkg;
  typedef enum logic [2:0] {IDLE, INTEG, FV_LEAD, LINE, HBLANK, FV_TAIL} state_t;
  localparam int DEF_H_BLANK = 8;
  localparam int DEF_FV_PRE = 4;
  localparam int DEF_FV_POST = 4;
  localparam logic [11:0] MAX_DIM = 12'd4095;
  function automatic logic [11:0] clamp12(input logic [15:0] x);
    return x > 16'(MAX_DIM) ? MAX_DIM : x[11:0];
  endfunction
  function automatic logic [23:0] max1(input logic [23:0] x);
    return x == '0 ? 24'd1 : x;
  endfunction
endpackage

// File: rtl/timing_gen_if.sv
// timing_gen_if: frame size/enable inputs and video timing outputs of timing_gen
interface timing_gen_if;
  logic [15:0] app_image_h;
  logic [15:0] app_image_w;
  logic sys_en;
  logic frame_valid;
  logic line_valid;
  logic data_valid;
  logic [15:0] dout;
  logic [11:0] line_cnt;
  logic [11:0] pixel_cnt;
  modport master(
    input app_image_h, app_image_w, sys_en,
    output frame_valid, line_valid, data_valid, dout, line_cnt, pixel_cnt
  );
  modport slave(
    output app_image_h, app_image_w, sys_en,
    input frame_valid, line_valid, data_valid, dout, line_cnt, pixel_cnt
  );
endinterface

// File: rtl/timing_gen.sv
// timing_gen: frame/line timing generator emitting a line+pixel test pattern
module timing_gen
  import timing_gen_pkg::*;
#(
  parameter logic [23:0] Integration_T = 24'd50,
  parameter int H_BLANK = DEF_H_BLANK,
  parameter int FV_PRE = DEF_FV_PRE,
  parameter int FV_POST = DEF_FV_POST
) (
  input logic clk,
  input logic rst_n,
  timing_gen_if.master tg
);
  state_t state, state_n;
  logic [23:0] cnt, cnt_n, dur;
  logic [11:0] ln, ln_n, h, h_n, w, w_n;
  logic start, last, last_line;
  always_comb begin
    dur = state == INTEG ? max1(Integration_T) :
          state == FV_LEAD ? max1(24'(FV_PRE)) :
          state == LINE ? {12'd0, w} :
          state == HBLANK ? max1(24'(H_BLANK)) :
          state == FV_TAIL ? max1(24'(FV_POST)) : 24'd1;
    last = cnt == dur - 24'd1;
    last_line = ln == h - 12'd1;
    start = tg.sys_en && tg.app_image_h != '0 && tg.app_image_w != '0;
    state_n = state;
    cnt_n = last ? '0 : cnt + 24'd1;
    ln_n = ln;
    h_n = h;
    w_n = w;
    case (state)
      IDLE: state_n = start ? INTEG : IDLE;
      INTEG: begin
        state_n = last ? FV_LEAD : INTEG;
        ln_n = last ? '0 : ln;
      end
      FV_LEAD, HBLANK: state_n = last ? LINE : state;
      LINE: begin
        state_n = !last ? LINE : last_line ? FV_TAIL : HBLANK;
        ln_n = last && !last_line ? ln + 12'd1 : ln;
      end
      FV_TAIL: state_n = !last ? FV_TAIL : start ? INTEG : IDLE;
      default: state_n = IDLE;
    endcase
    // frame size is sampled only when a new frame is about to begin
    if (start && (state == IDLE || (state == FV_TAIL && last))) begin
      h_n = clamp12(tg.app_image_h);
      w_n = clamp12(tg.app_image_w);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      ln <= '0;
      h <= '0;
      w <= '0;
      tg.frame_valid <= 1'b0;
      tg.line_valid <= 1'b0;
      tg.data_valid <= 1'b0;
      tg.dout <= '0;
      tg.line_cnt <= '0;
      tg.pixel_cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ln <= ln_n;
      h <= h_n;
      w <= w_n;
      tg.frame_valid <= state != IDLE && state != INTEG;
      tg.line_valid <= state == LINE;
      tg.data_valid <= state == LINE;
      tg.dout <= state == LINE ? 16'(ln) + 16'(cnt[11:0]) : '0;
      tg.line_cnt <= state == IDLE || state == INTEG ? '0 : ln;
      tg.pixel_cnt <= state == LINE ? cnt[11:0] : '0;
    end
endmodule

// File: tb/tb_timing_gen.sv
// tb_timing_gen: directed checks of timing_gen with default parameters
module tb_timing_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int lines, bad_len, fv_len, dv_mis, n;
  logic [15:0] d3, d198;
  logic [11:0] pc3, pc99;
  timing_gen_if tg();
  timing_gen dut (.clk(clk), .rst_n(rst_n), .tg(tg));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_fv(output int k);
    k = 0;
    while (tg.frame_valid !== 1'b1 && k < 20000) begin
      tick();
      k++;
    end
  endtask
  task automatic watch_frame(input int exp_w, input int act_line, input logic en_mid, input logic [15:0] h_mid);
    logic lv_prev;
    logic [15:0] prev_dout;
    logic [11:0] prev_pc, prev_ln;
    int len;
    lines = 0; bad_len = 0; fv_len = 0; dv_mis = 0; len = 0;
    d3 = '1; d198 = '1; pc3 = '1; pc99 = '1;
    lv_prev = 1'b0; prev_dout = '0; prev_pc = '0; prev_ln = '0;
    while (tg.frame_valid === 1'b1 && fv_len < 20000) begin
      fv_len++;
      if (tg.data_valid !== tg.line_valid || (tg.data_valid !== 1'b1 && tg.dout !== 16'd0)) dv_mis++;
      if (tg.line_valid === 1'b1 && !lv_prev) begin
        lines++;
        len = 0;
        if (tg.line_cnt == 12'd3) begin d3 = tg.dout; pc3 = tg.pixel_cnt; end
        if (int'(tg.line_cnt) == act_line) begin tg.sys_en = en_mid; tg.app_image_h = h_mid; end
      end
      if (tg.line_valid === 1'b1) len++;
      if (tg.line_valid !== 1'b1 && lv_prev) begin
        if (len != exp_w) bad_len++;
        if (prev_ln == 12'd99) begin d198 = prev_dout; pc99 = prev_pc; end
      end
      lv_prev = tg.line_valid === 1'b1;
      prev_dout = tg.dout; prev_pc = tg.pixel_cnt; prev_ln = tg.line_cnt;
      tick();
    end
  endtask
  task automatic test_reset();
    tg.sys_en = 1'b0; tg.app_image_h = 16'd0; tg.app_image_w = 16'd0;
    repeat (3) tick();
    checks++; if (tg.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b want 0", tg.frame_valid); end
    checks++; if (tg.line_valid !== 1'b0) begin errors++; $display("FAIL reset_lv got %b want 0", tg.line_valid); end
    checks++; if (tg.data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", tg.data_valid); end
    checks++; if (tg.dout !== 16'd0) begin errors++; $display("FAIL reset_dout got %0d want 0", tg.dout); end
    checks++; if (tg.line_cnt !== 12'd0) begin errors++; $display("FAIL reset_line_cnt got %0d want 0", tg.line_cnt); end
    checks++; if (tg.pixel_cnt !== 12'd0) begin errors++; $display("FAIL reset_pixel_cnt got %0d want 0", tg.pixel_cnt); end
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_zero_size();
    int nz;
    nz = 0;
    tg.app_image_h = 16'd100; tg.app_image_w = 16'd0; tg.sys_en = 1'b1;
    repeat (200) begin
      tick();
      if ({tg.frame_valid, tg.line_valid, tg.data_valid, tg.dout, tg.line_cnt, tg.pixel_cnt} !== '0) nz++;
    end
    checks++; if (nz != 0) begin errors++; $display("FAIL zero_w_outputs got %0d nonzero samples want 0", nz); end
  endtask
  task automatic test_frame();
    tg.app_image_w = 16'd100;
    wait_fv(n);
    checks++; if (n != 52) begin errors++; $display("FAIL first_fv_latency got %0d want 52", n); end
    watch_frame(100, -1, 1'b1, 16'd100);
    checks++; if (lines != 100) begin errors++; $display("FAIL lines got %0d want 100", lines); end
    checks++; if (bad_len != 0) begin errors++; $display("FAIL line_len got %0d bad lines want 0", bad_len); end
    checks++; if (fv_len != 10800) begin errors++; $display("FAIL fv_len got %0d want 10800", fv_len); end
    checks++; if (d3 !== 16'd3) begin errors++; $display("FAIL dout_line3 got %0d want 3", d3); end
    checks++; if (pc3 !== 12'd0) begin errors++; $display("FAIL pixel_line3 got %0d want 0", pc3); end
    checks++; if (d198 !== 16'd198) begin errors++; $display("FAIL dout_line99 got %0d want 198", d198); end
    checks++; if (pc99 !== 12'd99) begin errors++; $display("FAIL pixel_line99 got %0d want 99", pc99); end
    checks++; if (dv_mis != 0) begin errors++; $display("FAIL dv_dout got %0d bad samples want 0", dv_mis); end
    wait_fv(n);
    checks++; if (fv_len + n != 10850) begin errors++; $display("FAIL period got %0d want 10850", fv_len + n); end
  endtask
  task automatic test_h_change();
    watch_frame(100, 50, 1'b1, 16'd4);
    checks++; if (lines != 100) begin errors++; $display("FAIL hchg_cur_lines got %0d want 100", lines); end
    wait_fv(n);
    checks++; if (n != 50) begin errors++; $display("FAIL hchg_gap got %0d want 50", n); end
    tg.app_image_h = 16'd100;
    watch_frame(100, -1, 1'b1, 16'd100);
    checks++; if (lines != 4) begin errors++; $display("FAIL hchg_next_lines got %0d want 4", lines); end
    checks++; if (fv_len != 432) begin errors++; $display("FAIL hchg_next_fv_len got %0d want 432", fv_len); end
  endtask
  task automatic test_sys_en_drop();
    int nz;
    nz = 0;
    wait_fv(n);
    watch_frame(100, 50, 1'b0, 16'd100);
    checks++; if (lines != 100) begin errors++; $display("FAIL drop_lines got %0d want 100", lines); end
    checks++; if (fv_len != 10800) begin errors++; $display("FAIL drop_fv_len got %0d want 10800", fv_len); end
    repeat (200) begin
      if ({tg.frame_valid, tg.line_valid, tg.data_valid, tg.dout, tg.line_cnt, tg.pixel_cnt} !== '0) nz++;
      tick();
    end
    checks++; if (nz != 0) begin errors++; $display("FAIL drop_idle got %0d nonzero samples want 0", nz); end
  endtask
  task automatic test_reset_mid();
    tg.app_image_h = 16'd20; tg.app_image_w = 16'd20; tg.sys_en = 1'b1;
    n = 0;
    while (!(tg.line_valid === 1'b1 && tg.line_cnt == 12'd10) && n < 20000) begin
      tick();
      n++;
    end
    checks++; if (n >= 20000) begin errors++; $display("FAIL rst_reach_line10 got timeout want line 10"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tg.frame_valid, tg.line_valid, tg.data_valid, tg.dout, tg.line_cnt, tg.pixel_cnt} !== '0) begin
      errors++;
      $display("FAIL rst_async got fv=%b lv=%b line=%0d pix=%0d want all 0", tg.frame_valid, tg.line_valid, tg.line_cnt, tg.pixel_cnt);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    wait_fv(n);
    checks++; if (tg.line_cnt !== 12'd0) begin errors++; $display("FAIL rst_restart_line got %0d want 0", tg.line_cnt); end
    watch_frame(20, -1, 1'b1, 16'd20);
    checks++; if (lines != 20) begin errors++; $display("FAIL rst_restart_lines got %0d want 20", lines); end
    checks++; if (fv_len != 560) begin errors++; $display("FAIL rst_restart_fv_len got %0d want 560", fv_len); end
  endtask
  initial begin
    test_reset();
    test_zero_size();
    test_frame();
    test_h_change();
    test_sys_en_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
